rll_restore_seq: RTL

//  Sequencer for the rll_restore datapath on the DNA decode path. Takes one
//  2N-bit encoded strand word at a time (N nucleotides, 2 bits each) over a

---
 rtl/rll_restore_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rll_restore_seq.sv
// rll_restore_seq: feeds one encoded strand word at a time into the rll_restore
// datapath, waits out its latency, captures the variable-length result and
// packs the results MSB-first into a fixed-width output stream. The stream
// supports backpressure and flushes the remaining bits at the end of a frame.
module rll_restore_seq #(
    parameter int N      = 20,
    parameter int OUT_W  = 16,
    parameter int LAT    = 2,
    parameter int MAXLEN = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*N-1:0]              in_word,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [2*N-1:0]              rr_word_in,
    input  logic [MAXLEN-1:0]           rr_word_out,
    input  logic [6:0]                  rr_len,
    output logic [OUT_W-1:0]            out_data,
    output logic [$clog2(OUT_W+1)-1:0]  out_bits,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        len_err,
    output logic                        busy
);

    localparam int ACC_W  = OUT_W + MAXLEN;
    localparam int FILL_W = $clog2(ACC_W);
    localparam int OB_W   = $clog2(OUT_W + 1);
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SH_W   = ((FILL_W > 7) ? FILL_W : 7) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_PACK  = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_q_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [MAXLEN-1:0] cap_word_reg;
    logic [6:0]        cap_len_reg;

    // Packing datapath: field bits masked to the captured length, shifted so
    // the field's MSB lands just below the bits already pending in acc.
    logic [MAXLEN-1:0] field_bits;
    logic [ACC_W-1:0]  field_wide;
    logic [SH_W-1:0]   shamt;
    logic [ACC_W-1:0]  acc_app;
    logic [FILL_W-1:0] fill_app;
    logic [FILL_W-1:0] fill_pack;
    logic              len_ok;

    // Keep only bit positions below the captured length.
    generate
        for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_field_mask
            assign field_bits[gi] = cap_word_reg[gi] & (7'(gi) < cap_len_reg);
        end
    endgenerate

    // Append arithmetic; only meaningful when the captured length is legal,
    // which also guarantees fill+len fits inside acc.
    always_comb begin
        len_ok     = (cap_len_reg <= 7'(MAXLEN));
        field_wide = {{OUT_W{1'b0}}, field_bits};
        shamt      = SH_W'(ACC_W) - SH_W'(fill_reg) - SH_W'(cap_len_reg);
        acc_app    = acc_reg | (field_wide << shamt);
        fill_app   = fill_reg + FILL_W'(cap_len_reg);
        fill_pack  = len_ok ? fill_app : fill_reg;
    end

    // Output stream view of acc. Bits below fill are always zero, so the top
    // OUT_W bits of acc are already zero-padded for a partial flush word.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_bits  = '0;
        out_last  = 1'b0;
        case (state_reg)
            ST_EMIT: begin
                out_valid = 1'b1;
                out_data  = acc_reg[ACC_W-1 -: OUT_W];
                out_bits  = OB_W'(OUT_W);
                out_last  = last_q_reg && (fill_reg == FILL_W'(OUT_W));
            end
            ST_FLUSH: begin
                out_valid = 1'b1;
                out_data  = acc_reg[ACC_W-1 -: OUT_W];
                out_bits  = OB_W'(fill_reg);
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Handshake status; only one word is ever in flight.
    always_comb begin
        in_ready = rst && (state_reg == ST_IDLE);
        busy     = (state_reg != ST_IDLE);
    end

    // Sequencer: accept, wait datapath latency, capture, pack, emit/flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            last_q_reg   <= 1'b0;
            acc_reg      <= '0;
            fill_reg     <= '0;
            cap_word_reg <= '0;
            cap_len_reg  <= '0;
            rr_word_in   <= '0;
            len_err      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        rr_word_in <= in_word;
                        last_q_reg <= in_last;
                        cnt_reg    <= '0;
                        state_reg  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == CNT_W'(LAT - 1)) begin
                        cap_word_reg <= rr_word_out;
                        cap_len_reg  <= rr_len;
                        state_reg    <= ST_PACK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_PACK: begin
                    if (len_ok) begin
                        acc_reg  <= acc_app;
                        fill_reg <= fill_app;
                    end else begin
                        len_err <= 1'b1;
                    end
                    if (fill_pack >= FILL_W'(OUT_W)) begin
                        state_reg <= ST_EMIT;
                    end else if (last_q_reg) begin
                        state_reg <= ST_FLUSH;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        acc_reg  <= acc_reg << OUT_W;
                        fill_reg <= fill_reg - FILL_W'(OUT_W);
                        if (last_q_reg && (fill_reg != FILL_W'(OUT_W))) begin
                            state_reg <= ST_FLUSH;
                        end else begin
                            last_q_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_ready) begin
                        acc_reg    <= '0;
                        fill_reg   <= '0;
                        last_q_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
